// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: zero-operand ops skip the iteration phase and finish in one cycle.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [2:0]      op_reg;
  logic            neg_reg;
  logic            b_zero_reg;
  logic [4:0]      rd_pend_reg;
  logic [XLEN-1:0] addend_reg;
  logic [XLEN-1:0] hi_reg, lo_reg;
  logic [XLEN-1:0] result_reg;
  logic [4:0]      rd_reg;

  // Operand decode straight off the ID_EX outputs, used only at capture.
  logic            is_div_in, a_signed_in, b_signed_in, sign_a_in, sign_b_in;
  logic            neg_in, b_zero_in, accept;
  logic [XLEN-1:0] mag_a_in, mag_b_in;

  assign is_div_in   = funct3[2];
  assign a_signed_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sign_a_in   = a_signed_in & operand_a[XLEN-1];
  assign sign_b_in   = b_signed_in & operand_b[XLEN-1];
  assign mag_a_in    = sign_a_in ? (~operand_a + 1'b1) : operand_a;
  assign mag_b_in    = sign_b_in ? (~operand_b + 1'b1) : operand_b;
  assign b_zero_in   = (operand_b == '0);
  assign accept      = (state_reg == IDLE) && start && !flush;

  // Remainder follows the dividend; everything else negates on a sign mismatch.
  always_comb begin
    neg_in = sign_a_in ^ sign_b_in;
    if (funct3 == 3'b110) neg_in = sign_a_in;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic early_in;
  assign early_in = b_zero_in || (!is_div_in && (operand_a == '0));
`endif

  // One iteration step. Multiply: {hi,lo} accumulates with lo holding the multiplier.
  // Divide: lo holds the dividend shifting out and the quotient shifting in, hi the partial remainder.
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] hi_step, lo_step;

  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, addend_reg} : '0);
  assign div_shift = {hi_reg, lo_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, addend_reg};

  always_comb begin
    hi_step = mul_sum[XLEN:1];
    lo_step = {mul_sum[0], lo_reg[XLEN-1:1]};
    if (op_reg[2]) begin
      if (!div_diff[XLEN]) begin
        hi_step = div_diff[XLEN-1:0];
        lo_step = {lo_reg[XLEN-2:0], 1'b1};
      end else begin
        hi_step = div_shift[XLEN-1:0];
        lo_step = {lo_reg[XLEN-2:0], 1'b0};
      end
    end
  end

  function automatic logic [XLEN-1:0] finalize(input logic [2:0] op, input logic neg,
                                               input logic b_zero, input logic [XLEN-1:0] hi,
                                               input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] prod;
    prod = neg ? -{hi, lo} : {hi, lo};
    case (op)
      3'b000:                 finalize = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: finalize = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         finalize = b_zero ? '1 : (neg ? -lo : lo);
      default:                finalize = neg ? -hi : hi;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      op_reg      <= '0;
      neg_reg     <= 1'b0;
      b_zero_reg  <= 1'b0;
      rd_pend_reg <= '0;
      addend_reg  <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      result_reg  <= '0;
      rd_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg      <= funct3;
        neg_reg     <= neg_in;
        b_zero_reg  <= b_zero_in;
        rd_pend_reg <= rd_in;
        addend_reg  <= is_div_in ? mag_b_in : mag_a_in;
        lo_reg      <= is_div_in ? mag_a_in : mag_b_in;
        hi_reg      <= '0;
        count_reg   <= '0;
`ifdef MULDIV_EARLY_OUT_EN
        if (early_in) begin
          result_reg <= finalize(funct3, neg_in, b_zero_in, is_div_in ? mag_a_in : '0, '0);
          rd_reg     <= rd_in;
        end
`endif
      end else if (state_reg == CALC && !flush) begin
        hi_reg    <= hi_step;
        lo_reg    <= lo_step;
        count_reg <= count_reg + CW'(1);
        if (count_reg == CW'(XLEN - 1)) begin
          result_reg <= finalize(op_reg, neg_reg, b_zero_reg, hi_step, lo_step);
          rd_reg     <= rd_pend_reg;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    stall_req  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          stall_req = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
          state_next = early_in ? DONE : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        stall_req = 1'b1;
        if (flush)                              state_next = IDLE;
        else if (count_reg == CW'(XLEN - 1))    state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign rd_out = rd_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, aborts and random ops
// checked against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  rd_in = '0;
  logic        stall_req, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_result = '0;
  logic [4:0]  last_rd = '0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
    .stall_req(stall_req), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int ia, ib;
    ia = a; ib = b; sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    case (f)
      3'b000: begin p = ua * ub; ref_result = p[31:0]; end
      3'b001: begin p = sa * sb; ref_result = p[63:32]; end
      3'b010: begin p = sa * longint'(ub); ref_result = p[63:32]; end
      3'b011: begin p = ua * ub; ref_result = p[63:32]; end
      3'b100: begin
        if (b == 0) ref_result = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_result = 32'h80000000;
        else ref_result = ia / ib;
      end
      3'b101: ref_result = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 0) ref_result = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) ref_result = 0;
        else ref_result = ia % ib;
      end
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (b == 0 || (!f[2] && a == 0)) return 1;
`endif
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold_start);
    logic [31:0] exp;
    int lat, stall_bad, exp_lat;
    exp = ref_result(f, a, b);
    exp_lat = exp_latency(f, a, b);
    @(negedge clock);
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b; rd_in = rd;
    #1 check("stall_cycle0", 32'(stall_req), 32'd1);
    @(posedge clock);
    #1;
    if (!hold_start) start = 1'b0;
    operand_a = $urandom; operand_b = $urandom;
    funct3 = 3'($urandom); rd_in = 5'($urandom);
    lat = 0; stall_bad = 0;
    do begin
      @(negedge clock);
      lat++;
      if (!done && (!stall_req || !busy)) stall_bad++;
    end while (!done && lat < 100);
    start = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("stall_while_busy", 32'(stall_bad), 32'd0);
    check("stall_in_done", 32'(stall_req), 32'd0);
    check("busy_in_done", 32'(busy), 32'd1);
    check("result", result, exp);
    check("rd_out", 32'(rd_out), 32'(rd));
    $display("op f3=%0d a=0x%08h b=0x%08h rd=%0d result=0x%08h expect=0x%08h cycles=%0d",
             f, a, b, rd, result, exp, lat);
    last_result = exp; last_rd = rd;
    @(negedge clock);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    // Reset
    repeat (2) @(negedge clock);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stall", 32'(stall_req), 0);
    check("rst_result", result, 0);
    check("rst_rd", 32'(rd_out), 0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);

    // Directed operations
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b0);
    run_op(3'b001, 32'h80000000, 32'h80000000, 5'd6, 1'b0);
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 1'b0);
    run_op(3'b010, 32'hFFFFFFFF, 32'd2, 5'd8, 1'b0);
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd9, 1'b0);
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd10, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 5'd11, 1'b0);
    run_op(3'b111, 32'd100, 32'd7, 5'd12, 1'b0);
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, 1'b0);
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, 1'b0);
    run_op(3'b100, 32'd5, 32'd0, 5'd15, 1'b0);
    run_op(3'b110, 32'd5, 32'd0, 5'd16, 1'b0);
    run_op(3'b000, 32'd0, 32'd1234, 5'd17, 1'b0);
    // start held high during the whole operation must not re-trigger
    run_op(3'b101, 32'd12345, 32'd17, 5'd18, 1'b1);

    // Flush in cycle 10 of a DIVU
    @(negedge clock);
    start = 1'b1; funct3 = 3'b101; operand_a = 32'd1000; operand_b = 32'd7; rd_in = 5'd20;
    @(posedge clock); #1 start = 1'b0;
    repeat (10) @(negedge clock);
    flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    check("flush_busy", 32'(busy), 0);
    check("flush_stall", 32'(stall_req), 0);
    dones = 0;
    repeat (40) begin @(negedge clock); if (done) dones++; end
    check("flush_no_done", 32'(dones), 0);
    check("flush_result_held", result, last_result);
    check("flush_rd_held", 32'(rd_out), 32'(last_rd));

    // start and flush together
    @(negedge clock);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd4;
    #1 check("startflush_stall", 32'(stall_req), 0);
    @(posedge clock); #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clock);
    check("startflush_busy", 32'(busy), 0);

    // Reset mid-CALC
    @(negedge clock);
    start = 1'b1; funct3 = 3'b000; operand_a = 32'd3; operand_b = 32'd5; rd_in = 5'd21;
    @(posedge clock); #1 start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_stall", 32'(stall_req), 0);
    check("midrst_result", result, 0);
    check("midrst_rd", 32'(rd_out), 0);
    dones = 0;
    repeat (40) begin @(negedge clock); if (done) dones++; end
    check("midrst_no_done", 32'(dones), 0);

    // Random operations
    for (int i = 0; i < 24; i++)
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
